vfd_ramp_clk_gen: RTL and testbench

//  Parametrised programmable square-wave generator for the VFD switching

---
 rtl/vfd_pkg.sv | 14 +
 rtl/vfd_slew_step.sv | 34 +++
 rtl/vfd_ramp_clk_gen.sv | 95 +++++++++
 tb/tb_vfd_ramp_clk_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vfd_pkg.sv
// rtl/vfd_pkg.sv - shared state type and default sizing for the VFD clock chain
package vfd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_LOCKED = 2'd2
  } vfd_state_e;

  localparam int VFD_CNT_W      = 16;
  localparam int VFD_START_HALF = 4095;
  localparam int VFD_MIN_HALF   = 1;

endpackage

// File: rtl/vfd_slew_step.sv
// rtl/vfd_slew_step.sv - one clamped slew step of the half-period toward its target
module vfd_slew_step
  import vfd_pkg::*;
#(
  parameter int CNT_W = VFD_CNT_W
) (
  input  logic [CNT_W-1:0] i_cur,
  input  logic [CNT_W-1:0] i_eff,
  input  logic [CNT_W-1:0] i_step,
  output logic [CNT_W-1:0] o_next,
  output logic             o_done
);

  logic [CNT_W:0] w_up;
  logic [CNT_W:0] w_dn_lim;

  // One extra bit so neither direction can wrap before the clamp is applied
  assign w_up     = {1'b0, i_cur} + {1'b0, i_step};
  assign w_dn_lim = {1'b0, i_eff} + {1'b0, i_step};

  always_comb begin
    o_next = i_cur;
    if (i_step == '0) begin
      o_next = i_eff;
    end else if (i_cur > i_eff) begin
      o_next = ({1'b0, i_cur} <= w_dn_lim) ? i_eff : (i_cur - i_step);
    end else if (i_cur < i_eff) begin
      o_next = (w_up >= {1'b0, i_eff}) ? i_eff : w_up[CNT_W-1:0];
    end
  end

  assign o_done = (o_next == i_eff);

endmodule

// File: rtl/vfd_ramp_clk_gen.sv
// rtl/vfd_ramp_clk_gen.sv - soft-start programmable square-wave generator for the VFD chain
module vfd_ramp_clk_gen
  import vfd_pkg::*;
#(
  parameter int CNT_W      = VFD_CNT_W,
  parameter int START_HALF = VFD_START_HALF,
  parameter int MIN_HALF   = VFD_MIN_HALF
) (
  input  logic             i_clk_in,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_target_half,
  input  logic [CNT_W-1:0] i_ramp_step,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_cur_half,
  output logic             o_at_target
);

  localparam logic [CNT_W-1:0] START_V = CNT_W'(START_HALF);
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_HALF);

  vfd_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur_half;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_at_target;

  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] w_next_half;
  logic             w_step_done;
  logic             w_boundary;

  assign w_eff      = (i_target_half < MIN_V) ? MIN_V : i_target_half;
  assign w_boundary = (r_state != ST_IDLE) && (r_cnt == r_cur_half);

  vfd_slew_step #(
    .CNT_W (CNT_W)
  ) u_slew (
    .i_cur  (r_cur_half),
    .i_eff  (w_eff),
    .i_step (i_ramp_step),
    .o_next (w_next_half),
    .o_done (w_step_done)
  );

  always_ff @(posedge i_clk_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cur_half  <= START_V;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
      r_at_target <= 1'b0;
    end else begin
      r_tick      <= 1'b0;
      r_at_target <= (r_state == ST_LOCKED);
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
          if (i_enable) begin
            r_state    <= ST_RAMP;
            r_cur_half <= START_V;
          end
        end
        default: begin
          if (!w_boundary) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
            r_tick    <= 1'b1;
            // Half-period only changes on the rising boundary: whole periods stay symmetric
            if (!r_clk_out) begin
              if (r_state == ST_RAMP || w_eff != r_cur_half) begin
                r_cur_half <= w_next_half;
                r_state    <= w_step_done ? ST_LOCKED : ST_RAMP;
              end
            end else if (!i_enable) begin
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign o_clk_out   = r_clk_out;
  assign o_tick      = r_tick;
  assign o_cur_half  = r_cur_half;
  assign o_at_target = r_at_target;

endmodule

// File: tb/tb_vfd_ramp_clk_gen.sv
// tb/tb_vfd_ramp_clk_gen.sv - bench for vfd_ramp_clk_gen against a period-level model
module tb_vfd_ramp_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       r_rstn;
  logic [2:0]       r_en;
  logic [2:0][15:0] r_tgt;
  logic [2:0][15:0] r_stp;

  wire  [2:0]       w_tick;
  wire  [2:0]       w_clk;
  wire  [2:0]       w_at;
  wire  [15:0]      w_cur_a;
  wire  [15:0]      w_cur_b;
  wire  [7:0]       w_cur_c;

  int total;
  int bad;
  int m_cur [3];
  bit m_lock [3];

  vfd_ramp_clk_gen u_a (
    .i_clk_in (clk), .i_reset_n (r_rstn[0]), .i_enable (r_en[0]),
    .i_target_half (r_tgt[0]), .i_ramp_step (r_stp[0]),
    .o_clk_out (w_clk[0]), .o_tick (w_tick[0]), .o_cur_half (w_cur_a), .o_at_target (w_at[0])
  );

  vfd_ramp_clk_gen #(.CNT_W(16), .START_HALF(100), .MIN_HALF(1)) u_b (
    .i_clk_in (clk), .i_reset_n (r_rstn[1]), .i_enable (r_en[1]),
    .i_target_half (r_tgt[1]), .i_ramp_step (r_stp[1]),
    .o_clk_out (w_clk[1]), .o_tick (w_tick[1]), .o_cur_half (w_cur_b), .o_at_target (w_at[1])
  );

  vfd_ramp_clk_gen #(.CNT_W(8), .START_HALF(255), .MIN_HALF(1)) u_c (
    .i_clk_in (clk), .i_reset_n (r_rstn[2]), .i_enable (r_en[2]),
    .i_target_half (r_tgt[2][7:0]), .i_ramp_step (r_stp[2][7:0]),
    .o_clk_out (w_clk[2]), .o_tick (w_tick[2]), .o_cur_half (w_cur_c), .o_at_target (w_at[2])
  );

  function automatic logic [15:0] cur_of(input int k);
    case (k)
      0:       return w_cur_a;
      1:       return w_cur_b;
      default: return {8'h00, w_cur_c};
    endcase
  endfunction

  function automatic int eff_of(input int tgt);
    return (tgt < 1) ? 1 : tgt;
  endfunction

  // Half-period after one rising boundary, straight from the slew rules
  function automatic int model_next(input int cur, input int tgt, input int step);
    int eff;
    eff = eff_of(tgt);
    if (step == 0) return eff;
    if (cur > eff) return (cur - step < eff) ? eff : cur - step;
    if (cur < eff) return (cur + step > eff) ? eff : cur + step;
    return cur;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input int k, input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!w_tick[k] && n < budget);
    chk("tick_seen", {31'd0, w_tick[k]}, 1);
  endtask

  task automatic first_tick(input int k, input int start);
    int n;
    wait_tick(k, start + 10, n);
    chk("first_len", n, start + 2);
    chk("first_rise", {31'd0, w_clk[k]}, 1);
    m_cur[k]  = model_next(start, r_tgt[k], r_stp[k]);
    m_lock[k] = (m_cur[k] == eff_of(r_tgt[k]));
    chk("first_cur", cur_of(k), m_cur[k]);
  endtask

  // Starts just after a rising tick; pre = cycles of the high phase already spent
  task automatic check_period(input int k, input int pre);
    int n;
    wait_tick(k, m_cur[k] + 10, n);
    chk("fall_len", n + pre, m_cur[k] + 1);
    chk("fall_lvl", {31'd0, w_clk[k]}, 0);
    chk("at_target", {31'd0, w_at[k]}, {31'd0, m_lock[k]});
    wait_tick(k, m_cur[k] + 10, n);
    chk("rise_len", n, m_cur[k] + 1);
    chk("rise_lvl", {31'd0, w_clk[k]}, 1);
    m_cur[k]  = model_next(m_cur[k], r_tgt[k], r_stp[k]);
    m_lock[k] = (m_cur[k] == eff_of(r_tgt[k]));
    chk("cur_half", cur_of(k), m_cur[k]);
  endtask

  initial begin
    int n;
    int pre;
    int ticks;
    int highs;
    total  = 0;
    bad    = 0;
    r_rstn = '0;
    r_en   = '0;
    r_tgt  = '0;
    r_stp  = '0;
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      chk("rst_clk", {31'd0, w_clk[k]}, 0);
      chk("rst_tick", {31'd0, w_tick[k]}, 0);
      chk("rst_at", {31'd0, w_at[k]}, 0);
    end
    chk("rst_cur_a", cur_of(0), 4095);
    chk("rst_cur_b", cur_of(1), 100);
    chk("rst_cur_c", cur_of(2), 255);
    r_rstn = '1;
    cyc();

    // Default start value, step change straight to 469
    r_tgt[0] = 16'd469; r_stp[0] = 16'd0; r_en[0] = 1'b1;
    first_tick(0, 4095);
    chk("t1_cur", cur_of(0), 469);
    check_period(0, 0);
    check_period(0, 0);
    chk("t1_at", {31'd0, w_at[0]}, 1);
    r_en[0] = 1'b0;

    // Ramp down 100 -> 75 -> 50 -> 40
    r_tgt[1] = 16'd40; r_stp[1] = 16'd25; r_en[1] = 1'b1;
    first_tick(1, 100);
    chk("t2_75", cur_of(1), 75);
    check_period(1, 0);
    chk("t2_50", cur_of(1), 50);
    check_period(1, 0);
    chk("t2_40", cur_of(1), 40);
    check_period(1, 0);

    // Retarget mid high phase
    repeat (10) cyc();
    r_tgt[1] = 16'd90; r_stp[1] = 16'd30;
    check_period(1, 10);
    chk("t3_70", cur_of(1), 70);
    check_period(1, 0);
    chk("t3_90", cur_of(1), 90);
    check_period(1, 0);

    // Stop from the low phase, then a cancelled stop
    r_tgt[1] = 16'd10; r_stp[1] = 16'd0;
    check_period(1, 0);
    check_period(1, 0);
    wait_tick(1, 30, n);
    chk("t4_fall_len", n, 11);
    repeat (2) cyc();
    r_en[1] = 1'b0;
    wait_tick(1, 30, n);
    chk("t4_low_done", n + 2, 11);
    chk("t4_high", {31'd0, w_clk[1]}, 1);
    wait_tick(1, 30, n);
    chk("t4_high_done", n, 11);
    chk("t4_end_low", {31'd0, w_clk[1]}, 0);
    ticks = 0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      ticks += int'(w_tick[1]);
      highs += int'(w_clk[1]);
    end
    chk("t4_idle_ticks", ticks, 0);
    chk("t4_idle_high", highs, 0);
    chk("t4_cur_kept", cur_of(1), 10);
    r_en[1] = 1'b1;
    first_tick(1, 100);
    wait_tick(1, 30, n);
    chk("t4b_fall", n, 11);
    repeat (2) cyc();
    r_en[1] = 1'b0;
    wait_tick(1, 30, n);
    chk("t4b_rise", n + 2, 11);
    repeat (3) cyc();
    r_en[1] = 1'b1;
    wait_tick(1, 30, n);
    chk("t4b_fall2", n + 3, 11);
    wait_tick(1, 30, n);
    chk("t4b_continuous", n, 11);
    chk("t4b_lvl", {31'd0, w_clk[1]}, 1);

    // Floor at MIN_HALF
    r_tgt[1] = 16'd0; r_stp[1] = 16'd0;
    check_period(1, 0);
    chk("t5_min", cur_of(1), 1);
    check_period(1, 0);

    // Randomised retargets, applied at a random point of the high phase
    for (int it = 0; it < 8; it++) begin
      pre = $urandom_range(0, m_cur[1]);
      repeat (pre) cyc();
      r_tgt[1] = 16'($urandom_range(0, 120));
      r_stp[1] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      check_period(1, pre);
      for (int p = 0; p < 6 && !m_lock[1]; p++) check_period(1, 0);
    end

    // Async reset in the middle of a ramp
    r_tgt[1] = (m_cur[1] > 60) ? 16'd1 : 16'd120;
    r_stp[1] = 16'd1;
    check_period(1, 0);
    cyc();
    #2;
    chk("t5_pre_rst_high", {31'd0, w_clk[1]}, 1);
    r_rstn[1] = 1'b0;
    #1;
    chk("t5_rst_clk", {31'd0, w_clk[1]}, 0);
    chk("t5_rst_tick", {31'd0, w_tick[1]}, 0);
    chk("t5_rst_cur", cur_of(1), 100);
    chk("t5_rst_at", {31'd0, w_at[1]}, 0);
    r_rstn[1] = 1'b1;

    // 8-bit extreme: one step from 255 to 1
    r_tgt[2] = 16'd0; r_stp[2] = 16'd255; r_en[2] = 1'b1;
    first_tick(2, 255);
    chk("t6_cur", cur_of(2), 1);
    check_period(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
